// File: rtl/mult2_sequencer.sv
// Sequential unsigned WIDTH x WIDTH multiplier built on one 2x2-bit partial-product slice.
// Optional build macro MULT2_ZERO_SKIP_EN: a zero operand finishes one cycle after acceptance.
module mult2_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product,
  output logic                 busy
);

  localparam int DIGITS = WIDTH / 2;
  localparam int NSTEP  = DIGITS * DIGITS;
  localparam int KW     = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam int PW     = 2 * WIDTH;

  generate
    if ((WIDTH < 2) || (WIDTH % 2 != 0)) begin : g_bad_width
      $error("mult2_sequencer: WIDTH must be even and >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [PW-1:0]   acc, acc_next;
  logic [KW-1:0]   k;
  logic [1:0]      a_dig, b_dig;
  logic [3:0]      pp;
  logic            zero_op, last_step;
  int unsigned     kk, i_dig, j_dig;

  // Digit pair k walks a's digits fastest, then steps b's digit.
  always_comb begin
    kk        = 32'(k);
    i_dig     = kk % DIGITS;
    j_dig     = kk / DIGITS;
    a_dig     = 2'(a_reg >> (2 * i_dig));
    b_dig     = 2'(b_reg >> (2 * j_dig));
    pp        = 4'(a_dig) * 4'(b_dig);
    acc_next  = acc + (PW'(pp) << (2 * (i_dig + j_dig)));
`ifdef MULT2_ZERO_SKIP_EN
    zero_op   = (a_reg == '0) || (b_reg == '0);
`else
    zero_op   = 1'b0;
`endif
    last_step = (k == KW'(NSTEP - 1)) || zero_op;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      product   <= '0;
      acc       <= '0;
      k         <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            b_reg    <= b;
            acc      <= '0;
            k        <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next;
          if (last_step) begin
            // With a zero operand the first partial sum is already 0.
            product   <= acc_next;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            k <= k + KW'(1);
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult2_sequencer.sv
// Directed self-checking bench for mult2_sequencer (WIDTH=8).
module tb_mult2_sequencer;

  localparam int W = 8;

`ifdef MULT2_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 16;
`endif

  logic           clk = 1'b0;
  logic           rst, in_valid, in_ready, out_valid, out_ready, busy;
  logic [W-1:0]   a, b;
  logic [2*W-1:0] product;

  int n_checks = 0;
  int n_pass   = 0;

  mult2_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, measure latency, complete the output handshake.
  task automatic do_mul(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input int exp_prod, input int exp_lat, input string tag);
    int lat;
    in_valid = 1'b1; a = av; b = bv; out_ready = 1'b0;
    check({tag, ".in_ready_idle"}, 32'(in_ready), 1);
    tick();
    in_valid = 1'b0; a = ~av; b = ~bv;
    check({tag, ".busy"}, 32'(busy), 1);
    check({tag, ".in_ready_run"}, 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ".product"}, 32'(product), 32'(exp_prod));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, ".out_valid_clr"}, 32'(out_valid), 0);
    check({tag, ".in_ready_back"}, 32'(in_ready), 1);
    check({tag, ".product_held"}, 32'(product), 32'(exp_prod));
  endtask

  typedef struct { logic [W-1:0] av; logic [W-1:0] bv; int p; } vec_t;
  vec_t vecs[4] = '{'{8'd255, 8'd255, 65025}, '{8'd2, 8'd128, 256},
                    '{8'd170, 8'd85, 14450}, '{8'd7, 8'd0, 0}};

  initial begin
    int pulses, acc1, acc2, cyc, nacc, nout;
    int prods[2];
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    tick(); tick();
    check("rst.in_ready", 32'(in_ready), 1);
    check("rst.out_valid", 32'(out_valid), 0);
    check("rst.busy", 32'(busy), 0);
    check("rst.product", 32'(product), 0);
    rst = 1'b0;

    // Basic product and fixed latency
    do_mul(8'd13, 8'd11, 143, 16, "t1");
    foreach (vecs[n]) do_mul(vecs[n].av, vecs[n].bv, vecs[n].p,
                             (vecs[n].p == 0) ? ZLAT : 16, $sformatf("t2_%0d", n));
    do_mul(8'd0, 8'd77, 0, ZLAT, "t3");

    // Stalled consumer; a new request during DONE must be ignored
    in_valid = 1'b1; a = 8'd200; b = 8'd3;
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin tick(); cyc++; end
    check("t4.latency", 32'(cyc), 16);
    in_valid = 1'b1; a = 8'd1; b = 8'd1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("t4.hold_valid", 32'(out_valid), 1);
      check("t4.hold_product", 32'(product), 600);
      check("t4.hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t4.released", 32'(out_valid), 0);
    do_mul(8'd1, 8'd1, 1, 16, "t4b");

    // Reset in the middle of a run
    in_valid = 1'b1; a = 8'd99; b = 8'd99;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check("t5.in_ready", 32'(in_ready), 1);
    check("t5.out_valid", 32'(out_valid), 0);
    check("t5.product", 32'(product), 0);
    check("t5.busy", 32'(busy), 0);
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (out_valid) pulses++;
    end
    check("t5.no_out", 32'(pulses), 0);

    // Back-to-back with in_valid held high
    in_valid = 1'b1; a = 8'd3; b = 8'd5; out_ready = 1'b1;
    nacc = 0; nout = 0; acc1 = 0; acc2 = 0;
    for (cyc = 0; cyc < 80; cyc++) begin
      if (in_valid && in_ready) begin
        nacc++;
        if (nacc == 1) acc1 = cyc;
        else acc2 = cyc;
      end
      tick();
      if (nacc == 1) begin a = 8'd15; b = 8'd15; end
      if (nacc >= 2) in_valid = 1'b0;
      if (out_valid) begin
        if (nout < 2) prods[nout] = int'(product);
        nout++;
      end
    end
    out_ready = 1'b0;
    check("t6.accepts", 32'(nacc), 2);
    check("t6.spacing", 32'(acc2 - acc1), 18);
    check("t6.pulses", 32'(nout), 2);
    check("t6.prod0", 32'(prods[0]), 15);
    check("t6.prod1", 32'(prods[1]), 225);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
